// File: rtl/fetch_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module  : fetch_ctrl_if
// Brief   : Memory, redirect and decode handshake bundle for fetch_ctrl.
// Rev     : 1.0  initial release
// ============================================================================
interface fetch_ctrl_if #(
  parameter int DWIDTH = 32,
  parameter int AWIDTH = 32
);
  logic              mem_req_o;
  logic [AWIDTH-1:0] mem_addr_o;
  logic              mem_gnt_i;
  logic              mem_rvalid_i;
  logic [DWIDTH-1:0] mem_rdata_i;
  logic              redirect_i;
  logic [AWIDTH-1:0] redirect_pc_i;
  logic              insn_ready_i;
  logic              insn_valid_o;
  logic [DWIDTH-1:0] insn_o;
  logic [AWIDTH-1:0] pc_o;

  modport master (
    output mem_req_o, mem_addr_o, insn_valid_o, insn_o, pc_o,
    input  mem_gnt_i, mem_rvalid_i, mem_rdata_i, redirect_i, redirect_pc_i, insn_ready_i
  );

  modport slave (
    input  mem_req_o, mem_addr_o, insn_valid_o, insn_o, pc_o,
    output mem_gnt_i, mem_rvalid_i, mem_rdata_i, redirect_i, redirect_pc_i, insn_ready_i
  );
endinterface
`default_nettype wire

// File: rtl/fetch_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : fetch_ctrl
// Brief   : Single-outstanding instruction fetch controller with redirect.
// Rev     : 1.0  initial release
// ============================================================================
module fetch_ctrl #(
  parameter int                DWIDTH   = 32,
  parameter int                AWIDTH   = 32,
  parameter logic [AWIDTH-1:0] BASEADDR = AWIDTH'(32'h0100_0000)
) (
  input  wire logic      clk,
  input  wire logic      rst,
  fetch_ctrl_if.master   bus
);

  localparam logic [2:0] c_IDLE  = 3'd0;
  localparam logic [2:0] c_REQ   = 3'd1;
  localparam logic [2:0] c_WAIT  = 3'd2;
  localparam logic [2:0] c_DRAIN = 3'd3;
  localparam logic [2:0] c_OUT   = 3'd4;

  logic [2:0]        r_state;
  logic [AWIDTH-1:0] r_fpc;
  logic [AWIDTH-1:0] r_rpc;
  logic [AWIDTH-1:0] r_pc;
  logic [DWIDTH-1:0] r_insn;
  logic              r_valid;

  logic [AWIDTH-1:0] w_redir_pc;
  logic [AWIDTH-1:0] w_next_pc;

  assign w_redir_pc = {bus.redirect_pc_i[AWIDTH-1:2], 2'b00};
  assign w_next_pc  = r_rpc + AWIDTH'(4);

  assign bus.mem_req_o    = (r_state == c_REQ);
  assign bus.mem_addr_o   = r_fpc;
  assign bus.insn_valid_o = r_valid;
  assign bus.insn_o       = r_insn;
  assign bus.pc_o         = r_pc;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= c_IDLE;
      r_fpc   <= BASEADDR;
      r_rpc   <= BASEADDR;
      r_pc    <= BASEADDR;
      r_insn  <= '0;
      r_valid <= 1'b0;
    end else if (bus.redirect_i) begin
      // A granted-but-unanswered request must still be drained before refetching.
      r_fpc   <= w_redir_pc;
      r_valid <= 1'b0;
      case (r_state)
        c_REQ:   r_state <= bus.mem_gnt_i    ? c_DRAIN : c_REQ;
        c_WAIT:  r_state <= bus.mem_rvalid_i ? c_REQ   : c_DRAIN;
        c_DRAIN: r_state <= bus.mem_rvalid_i ? c_REQ   : c_DRAIN;
        default: r_state <= c_REQ;
      endcase
    end else begin
      case (r_state)
        c_IDLE: r_state <= c_REQ;
        c_REQ: begin
          if (bus.mem_gnt_i) begin
            r_rpc   <= r_fpc;
            r_state <= c_WAIT;
          end
        end
        c_WAIT: begin
          if (bus.mem_rvalid_i) begin
            r_insn  <= bus.mem_rdata_i;
            r_pc    <= r_rpc;
            r_valid <= 1'b1;
            r_fpc   <= w_next_pc;
            r_state <= c_OUT;
          end
        end
        c_DRAIN: begin
          if (bus.mem_rvalid_i) begin
            r_state <= c_REQ;
          end
        end
        c_OUT: begin
          if (bus.insn_ready_i) begin
            r_valid <= 1'b0;
            r_state <= c_REQ;
          end
        end
        default: r_state <= c_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_fetch_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : tb_fetch_ctrl
// Brief   : Directed and random stimulus for fetch_ctrl against a transaction model.
// Rev     : 1.0  initial release
// ============================================================================
module tb_fetch_ctrl;

  localparam logic [31:0] c_BASE = 32'h0100_0000;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_errors;

  fetch_ctrl_if #(.DWIDTH(32), .AWIDTH(32)) bus ();

  fetch_ctrl #(.DWIDTH(32), .AWIDTH(32), .BASEADDR(c_BASE)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Transaction-level view: a pending-response flag, a kill flag, a held slot.
  logic        m_known;
  logic        m_gap;
  logic        m_out;
  logic        m_kill;
  logic        m_hold;
  logic [31:0] m_next;
  logic [31:0] m_oaddr;
  logic [31:0] m_pc;
  logic [31:0] m_insn;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s at %0t: got %h expected %h", tag, $time, obs, exp);
    end
  endtask

  function automatic logic m_req();
    return m_known && !m_gap && !m_out && !m_hold;
  endfunction

  task automatic model_edge(input logic rs, input logic g, input logic v, input logic [31:0] d,
                            input logic r, input logic [31:0] rp, input logic y);
    if (rs) begin
      m_known = 1'b1; m_gap = 1'b1; m_out = 1'b0; m_kill = 1'b0; m_hold = 1'b0;
      m_next  = c_BASE; m_pc = c_BASE; m_insn = '0;
      return;
    end
    if (!m_known) return;
    if (m_gap) begin
      m_gap = 1'b0;
    end else if (m_req()) begin
      if (g) begin
        m_out = 1'b1; m_kill = r; m_oaddr = m_next;
      end
    end else if (m_out) begin
      if (v) begin
        m_out = 1'b0;
        if (!m_kill && !r) begin
          m_hold = 1'b1; m_insn = d; m_pc = m_oaddr; m_next = m_oaddr + 32'd4;
        end
      end else if (r) begin
        m_kill = 1'b1;
      end
    end else if (m_hold && y) begin
      m_hold = 1'b0;
    end
    if (r) begin
      m_next = {rp[31:2], 2'b00};
      m_hold = 1'b0;
    end
  endtask

  task automatic cycle(input logic rs, input logic g, input logic v, input logic [31:0] d,
                       input logic r, input logic [31:0] rp, input logic y);
    rst               = rs;
    bus.mem_gnt_i     = g;
    bus.mem_rvalid_i  = v;
    bus.mem_rdata_i   = d;
    bus.redirect_i    = r;
    bus.redirect_pc_i = rp;
    bus.insn_ready_i  = y;
    @(negedge clk);
    if (m_known) begin
      chk("mem_req", 32'(bus.mem_req_o), 32'(m_req()));
      if (m_req()) chk("mem_addr", bus.mem_addr_o, m_next);
      chk("insn_valid", 32'(bus.insn_valid_o), 32'(m_hold));
      chk("insn", bus.insn_o, m_insn);
      chk("pc", bus.pc_o, m_pc);
    end
    @(posedge clk);
    model_edge(rs, g, v, d, r, rp, y);
    #1;
  endtask

  task automatic go(input logic g, input logic v, input logic [31:0] d,
                    input logic r, input logic [31:0] rp, input logic y);
    cycle(1'b0, g, v, d, r, rp, y);
  endtask

  task automatic do_reset();
    cycle(1'b1, 1'b0, 1'b0, '0, 1'b0, '0, 1'b0);
    cycle(1'b1, 1'b0, 1'b0, '0, 1'b0, '0, 1'b0);
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    m_known  = 1'b0;
    m_gap = 1'b0; m_out = 1'b0; m_kill = 1'b0; m_hold = 1'b0;
    m_next = '0; m_oaddr = '0; m_pc = '0; m_insn = '0;

    // Streaming: grant and response each one cycle after the request.
    do_reset();
    chk("rst_valid", 32'(bus.insn_valid_o), 32'd0);
    chk("rst_pc", bus.pc_o, c_BASE);
    for (int i = 0; i < 10; i++) go(1'b1, 1'b1, 32'hA000_0000 + 32'(i), 1'b0, '0, 1'b1);
    chk("stream_pc", bus.pc_o, c_BASE + 32'd8);

    // Backpressure: hold the output for three extra cycles.
    do_reset();
    go(1'b0, 1'b0, '0, 1'b0, '0, 1'b0);
    go(1'b1, 1'b0, '0, 1'b0, '0, 1'b0);
    go(1'b0, 1'b1, 32'h1234_5678, 1'b0, '0, 1'b0);
    for (int i = 0; i < 3; i++) go(1'b1, 1'b1, 32'hFFFF_0000, 1'b0, '0, 1'b0);
    go(1'b0, 1'b0, '0, 1'b0, '0, 1'b1);
    chk("bp_next_addr", bus.mem_addr_o, c_BASE + 32'd4);

    // Redirect while waiting for the response.
    do_reset();
    go(1'b0, 1'b0, '0, 1'b0, '0, 1'b0);
    go(1'b1, 1'b0, '0, 1'b0, '0, 1'b0);
    go(1'b0, 1'b0, '0, 1'b1, 32'h0100_0103, 1'b0);
    go(1'b0, 1'b1, 32'h5555_AAAA, 1'b0, '0, 1'b0);
    chk("drain_addr", bus.mem_addr_o, 32'h0100_0100);
    chk("drain_valid", 32'(bus.insn_valid_o), 32'd0);

    // Redirect coinciding with the response.
    do_reset();
    go(1'b0, 1'b0, '0, 1'b0, '0, 1'b0);
    go(1'b1, 1'b0, '0, 1'b0, '0, 1'b0);
    go(1'b0, 1'b1, 32'hDEAD_BEEF, 1'b1, 32'h0100_0200, 1'b0);
    chk("rv_redir_addr", bus.mem_addr_o, 32'h0100_0200);
    chk("rv_redir_insn", bus.insn_o, 32'd0);
    go(1'b1, 1'b0, '0, 1'b0, '0, 1'b0);
    go(1'b0, 1'b1, 32'h0BAD_F00D, 1'b0, '0, 1'b0);
    go(1'b0, 1'b0, '0, 1'b0, '0, 1'b1);

    // Grant withheld for four cycles.
    do_reset();
    go(1'b0, 1'b0, '0, 1'b0, '0, 1'b0);
    for (int i = 0; i < 4; i++) go(1'b0, 1'b0, '0, 1'b0, '0, 1'b0);
    go(1'b1, 1'b0, '0, 1'b0, '0, 1'b0);

    // Address wrap at the top of the space.
    go(1'b0, 1'b0, '0, 1'b1, 32'hFFFF_FFFE, 1'b0);
    go(1'b0, 1'b1, '0, 1'b0, '0, 1'b0);
    go(1'b1, 1'b0, '0, 1'b0, '0, 1'b0);
    go(1'b0, 1'b1, 32'h7777_7777, 1'b0, '0, 1'b0);
    chk("wrap_pc", bus.pc_o, 32'hFFFF_FFFC);
    go(1'b0, 1'b0, '0, 1'b0, '0, 1'b1);
    chk("wrap_addr", bus.mem_addr_o, 32'h0000_0000);

    // Reset while waiting, stale response right after reset.
    do_reset();
    go(1'b0, 1'b0, '0, 1'b0, '0, 1'b0);
    go(1'b1, 1'b0, '0, 1'b0, '0, 1'b0);
    cycle(1'b1, 1'b0, 1'b0, '0, 1'b0, '0, 1'b0);
    go(1'b0, 1'b1, 32'hBAD0_0BAD, 1'b0, '0, 1'b0);
    chk("stale_valid", 32'(bus.insn_valid_o), 32'd0);
    chk("stale_insn", bus.insn_o, 32'd0);
    chk("stale_req", 32'(bus.mem_req_o), 32'd1);
    chk("stale_addr", bus.mem_addr_o, c_BASE);

    // Random traffic; responses and grants may arrive in any state.
    for (int i = 0; i < 3000; i++) begin
      cycle(($urandom % 100) == 0, ($urandom % 3) != 0, ($urandom % 2) == 0, $urandom,
            ($urandom % 12) == 0, $urandom, ($urandom % 3) != 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/fetch_ctrl.md
FETCH_CTRL -- requirements
Module: fetch_ctrl

Interface
REQ-001 The block SHALL have parameter DWIDTH, default 32, instruction width in bits.
REQ-002 The block SHALL have parameter AWIDTH, default 32, address width in bits.
REQ-003 The block SHALL have parameter BASEADDR, default 32'h01000000, first fetch address after reset.
REQ-004 The block SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-005 The block SHALL have port rst  input  1  synchronous, active-high reset.
REQ-006 The block SHALL have port mem_req_o  output  1  instruction-memory request valid.
REQ-007 The block SHALL have port mem_addr_o  output  AWIDTH  request address.
REQ-008 The block SHALL have port mem_gnt_i  input  1  memory accepts the request this cycle.
REQ-009 The block SHALL have port mem_rvalid_i  input  1  read data valid this cycle.
REQ-010 The block SHALL have port mem_rdata_i  input  DWIDTH  read data.
REQ-011 The block SHALL have port redirect_i  input  1  pipeline requests a change of fetch PC.
REQ-012 The block SHALL have port redirect_pc_i  input  AWIDTH  new fetch PC.
REQ-013 The block SHALL have port insn_ready_i  input  1  decode accepts the held instruction.
REQ-014 The block SHALL have port insn_valid_o  output  1  insn_o and pc_o hold a valid instruction.
REQ-015 The block SHALL have port insn_o  output  DWIDTH  fetched instruction.
REQ-016 The block SHALL have port pc_o  output  AWIDTH  address of insn_o.

Function
REQ-017 The block SHALL implement the states IDLE, REQ, WAIT, DRAIN and OUT, and SHALL keep an internal fetch PC register fpc.
REQ-018 IDLE SHALL move to REQ unconditionally on the next cycle.
REQ-019 In REQ, mem_req_o SHALL be 1 and mem_addr_o SHALL equal fpc; mem_req_o SHALL be 0 in all other states.
REQ-020 In REQ with mem_gnt_i=1, the block SHALL latch fpc as the request PC and move to WAIT.
REQ-021 In REQ with mem_gnt_i=0, the block SHALL stay in REQ with mem_addr_o unchanged, except as REQ-026 allows.
REQ-022 In WAIT with mem_rvalid_i=1, the block SHALL, on the next cycle, set insn_o=mem_rdata_i, pc_o=request PC, insn_valid_o=1 and fpc=request PC+4 (modulo 2^AWIDTH), and SHALL move to OUT.
REQ-023 Response-to-output latency SHALL be exactly 1 cycle.
REQ-024 In OUT with insn_ready_i=1, insn_valid_o SHALL clear and the state SHALL move to REQ.
REQ-025 In OUT with insn_ready_i=0, insn_o, pc_o and insn_valid_o SHALL stay stable and no request SHALL be issued.
REQ-026 On redirect_i=1, fpc SHALL load {redirect_pc_i[AWIDTH-1:2], 2'b00} and insn_valid_o SHALL clear on the next cycle; redirect has priority over every other event.
REQ-027 Redirect next-state rules SHALL be:
- IDLE, REQ without gnt, OUT -> REQ
- REQ with gnt -> DRAIN
- WAIT with mem_rvalid_i=0 -> DRAIN
- WAIT with mem_rvalid_i=1 -> REQ, with the response discarded
REQ-028 DRAIN SHALL discard the outstanding response and move to REQ on mem_rvalid_i=1; a redirect in DRAIN SHALL update fpc only.
REQ-029 The block SHALL have at most one outstanding memory request.
REQ-030 mem_rvalid_i SHALL be ignored in IDLE, REQ and OUT.
REQ-031 Best-case throughput SHALL be one instruction per 3 cycles (REQ, WAIT, OUT) when gnt and rvalid each arrive 1 cycle after the request.
REQ-032 PC increment SHALL wrap silently at 2^AWIDTH.

Reset
REQ-033 While rst=1, the block SHALL set: state=IDLE, fpc=BASEADDR, pc_o=BASEADDR, insn_o=0, insn_valid_o=0, mem_req_o=0.
REQ-034 Reset SHALL take effect from any state, including WAIT; a response belonging to a pre-reset request SHALL be ignored.
REQ-035 The first request after reset SHALL be issued 2 cycles after rst deasserts, with address BASEADDR.

Verification
REQ-036 Scenario, streaming: gnt=1 in REQ, rvalid 1 cycle after gnt, ready=1 -> request addresses 0x01000000, 0x01000004, 0x01000008; pc_o matches each; insn_o equals rdata.
REQ-037 Scenario, backpressure: insn_valid_o=1 with insn_ready_i=0 for 3 cycles -> insn_o and pc_o stable, mem_req_o=0; ready=1 -> next request at pc_o+4.
REQ-038 Scenario, redirect in WAIT: redirect_pc_i=0x01000103 -> response discarded via DRAIN, insn_valid_o stays 0, next mem_addr_o=0x01000100.
REQ-039 Scenario, redirect with rvalid in the same cycle: rdata=0xDEADBEEF -> 0xDEADBEEF never presented; next request uses the redirect address.
REQ-040 Scenario, gnt withheld 4 cycles: mem_req_o held at 1 and mem_addr_o stable for all 5 cycles.
REQ-041 Scenario, rst asserted in WAIT, rvalid arriving 1 cycle after rst deasserts: response ignored, all outputs at reset values, first request to 0x01000000.
